adma2_desc_fetch: RTL

ADMA2 descriptor fetch unit for the SD host controller. It walks the descriptor table in system memory starting at the ADMA System Address, reads each 64-bit descriptor line as two 32-bit words, and decodes it. Transfer descriptors are handed to the DMA transfer FSM downstream; link and nop descriptors are resolved internally. It implements the ST_FDS/ST_CADR address handling and feeds `data_address`, `lenght`, `Attribute` and `valid` to the DMA block.

---
 rtl/adma2_desc_fetch_if.sv | 24 ++
 rtl/adma2_desc_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adma2_desc_fetch_if.sv
// Memory read bus and descriptor hand-off bundle between the ADMA2 descriptor
// fetch unit (master) and its memory/DMA environment (slave).
interface adma2_desc_fetch_if;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_ack;
    logic [31:0] mem_rd_data;
    logic        valid;
    logic [63:0] data_address;
    logic [15:0] lenght;
    logic [16:0] xfer_bytes;
    logic [5:0]  Attribute;
    logic        next_req;

    modport master (
        output mem_rd_req, mem_rd_addr, valid, data_address, lenght, xfer_bytes, Attribute,
        input  mem_rd_ack, mem_rd_data, next_req
    );

    modport slave (
        input  mem_rd_req, mem_rd_addr, valid, data_address, lenght, xfer_bytes, Attribute,
        output mem_rd_ack, mem_rd_data, next_req
    );
endinterface

// File: rtl/adma2_desc_fetch.sv
// ADMA2 descriptor fetch unit: walks the descriptor table, resolves link/nop
// entries internally and presents transfer descriptors to the DMA engine.
module adma2_desc_fetch #(
    parameter int MAX_SKIP = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                STOP,
    input  logic [31:0]         desc_base,
    output logic [31:0]         sys_addr,
    output logic                busy,
    output logic                adma_err,
    adma2_desc_fetch_if.master  bus
);
    localparam int SKIP_W = $clog2(MAX_SKIP + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_LO   = 3'd1,
        ST_RD_HI   = 3'd2,
        ST_DECODE  = 3'd3,
        ST_PRESENT = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         ptr_q, ptr_d;
    logic [31:0]         w0_q, w0_d;
    logic [31:0]         w1_q, w1_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic [SKIP_W-1:0]   skip_inc_s;
    logic                err_q, err_d;
    logic                req_q, req_d;
    logic [31:0]         addr_q, addr_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic [31:0]         daddr_q, daddr_d;
    logic [15:0]         len_q, len_d;
    logic [16:0]         xfer_q, xfer_d;
    logic [5:0]          attr_q, attr_d;
    logic                is_link_s;
    logic                w0_unused_s;

    // Reserved descriptor bits carry no meaning for this unit.
    assign w0_unused_s = ^w0_q[15:6];
    assign is_link_s   = (w0_q[5:4] == 2'b11);
    assign skip_inc_s  = skip_q + SKIP_W'(1);

    // Next-state, pointer, skip counter and error flag.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        skip_d  = skip_q;
        err_d   = err_q;
        if (STOP) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_ERROR: begin
                    if (start) begin
                        ptr_d = desc_base;
                        if (desc_base[2:0] != 3'b000) begin
                            state_d = ST_ERROR;
                            err_d   = 1'b1;
                        end else begin
                            state_d = ST_RD_LO;
                            err_d   = 1'b0;
                            skip_d  = '0;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_RD_LO: begin
                    if (bus.mem_rd_ack) begin
                        w0_d    = bus.mem_rd_data;
                        state_d = ST_RD_HI;
                    end else begin
                        state_d = ST_RD_LO;
                    end
                end
                ST_RD_HI: begin
                    if (bus.mem_rd_ack) begin
                        w1_d    = bus.mem_rd_data;
                        state_d = ST_DECODE;
                    end else begin
                        state_d = ST_RD_HI;
                    end
                end
                ST_DECODE: begin
                    if (!w0_q[0]) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else if (w0_q[5:4] == 2'b10) begin
                        skip_d  = '0;
                        state_d = ST_PRESENT;
                    end else if (is_link_s && (w1_q[2:0] != 3'b000)) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end else if (w0_q[1]) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Bounded chain of non-transfer entries guards against table loops.
                        skip_d = skip_inc_s;
                        if (skip_inc_s == SKIP_W'(MAX_SKIP)) begin
                            state_d = ST_ERROR;
                            err_d   = 1'b1;
                        end else begin
                            ptr_d   = is_link_s ? w1_q : (ptr_q + 32'd8);
                            state_d = ST_RD_LO;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (bus.next_req) begin
                        if (w0_q[1]) begin
                            state_d = ST_IDLE;
                        end else begin
                            ptr_d   = ptr_q + 32'd8;
                            state_d = ST_RD_LO;
                        end
                    end else begin
                        state_d = ST_PRESENT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output values derived from the next state so every output is a flop.
    always_comb begin
        req_d   = (state_d == ST_RD_LO) || (state_d == ST_RD_HI);
        valid_d = (state_d == ST_PRESENT);
        busy_d  = (state_d != ST_IDLE) && (state_d != ST_ERROR);
        case (state_d)
            ST_RD_LO: addr_d = ptr_d;
            ST_RD_HI: addr_d = ptr_d + 32'd4;
            default:  addr_d = addr_q;
        endcase
        if ((state_q == ST_DECODE) && (state_d == ST_PRESENT)) begin
            daddr_d = w1_q;
            len_d   = w0_q[31:16];
            xfer_d  = (w0_q[31:16] == 16'h0000) ? 17'h10000 : {1'b0, w0_q[31:16]};
            attr_d  = w0_q[5:0];
        end else begin
            daddr_d = daddr_q;
            len_d   = len_q;
            xfer_d  = xfer_q;
            attr_d  = attr_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 32'h0;
            w0_q    <= 32'h0;
            w1_q    <= 32'h0;
            skip_q  <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= 32'h0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            daddr_q <= 32'h0;
            len_q   <= 16'h0;
            xfer_q  <= 17'h10000;
            attr_q  <= 6'h0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            skip_q  <= skip_d;
            err_q   <= err_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            daddr_q <= daddr_d;
            len_q   <= len_d;
            xfer_q  <= xfer_d;
            attr_q  <= attr_d;
        end
    end

    assign bus.mem_rd_req   = req_q;
    assign bus.mem_rd_addr  = addr_q;
    assign bus.valid        = valid_q;
    assign bus.data_address = {32'h0, daddr_q};
    assign bus.lenght       = len_q;
    assign bus.xfer_bytes   = xfer_q;
    assign bus.Attribute    = attr_q;
    assign sys_addr         = ptr_q;
    assign busy             = busy_q;
    assign adma_err         = err_q;
endmodule
